// File: rtl/accel_arb_pkg.sv
// Shared types and default constants for the accelerator port arbiter.
// Holds the FSM state enum, the latched operation enum and parameter defaults.
package accel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OP_WR,
        OP_RD
    } op_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_RD_W        = 512;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/accel_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick over a request vector.
// Ports: req (per-channel request), ptr (first channel to consider),
//        pick (one-hot winner), idx (winner index), any (some request set).
module rr_arbiter
    import accel_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = $clog2(DEF_NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] pick,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Scan channels ptr, ptr+1, ... with wrap; the first requester wins.
    always_comb begin
        int c;
        c    = 0;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(ptr) + k) % NUM_CH;
            if (!any && req[c]) begin
                any     = 1'b1;
                idx     = IDX_W'(c);
                pick[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/accel_port_arbiter.sv
// accel_port_arbiter: shares one CPU accelerator port among NUM_CH channels,
// one outstanding transaction at a time, round-robin between channels.
// Ports: clk/rst (sync, active-high); ch_* request inputs and per-channel
//        grant/done/valid/err pulses plus the shared ch_rd_data line;
//        accel_* drives the CPU port and accepts its responses.
// Optional macro ACCEL_ARB_TIMEOUT_EN adds a WAIT timeout raising ch_err.
module accel_port_arbiter
    import accel_arb_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RD_W        = DEF_RD_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_wrt_en,
    input  logic [NUM_CH-1:0]        ch_rd_en,
    input  logic [NUM_CH*ADDR_W-1:0] ch_wrt_addr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_rd_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wrt_data,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_wrt_done,
    output logic [NUM_CH-1:0]        ch_rd_valid,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [RD_W-1:0]          ch_rd_data,
    output logic [ADDR_W-1:0]        accel_addr,
    output logic [DATA_W-1:0]        accel_wrt_data,
    output logic                     accel_wrt_en,
    output logic                     accel_rd_en,
    input  logic                     accel_wrt_done,
    input  logic                     accel_rd_valid,
    input  logic [RD_W-1:0]          accel_rd_data
);

    localparam int IDX_W = $clog2(NUM_CH);

    state_t             state;
    state_t             state_n;
    op_t                op;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  pick;
    logic [IDX_W-1:0]   idx;
    logic               any;
    logic               resp;
    logic               complete;
    logic               tmo_hit;
    logic               tmo;

    assign req      = ch_wrt_en | ch_rd_en;
    assign ptr_next = (owner == IDX_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;

    // Only the response matching the latched op can complete the transaction.
    assign resp = (op == OP_WR) ? accel_wrt_done : accel_rd_valid;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (idx),
        .any  (any)
    );

`ifdef ACCEL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of WAIT cycles already completed.
    assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state != WAIT)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n      = state;
        accel_wrt_en = 1'b0;
        accel_rd_en  = 1'b0;
        ch_grant     = '0;
        complete     = 1'b0;
        tmo          = 1'b0;
        unique case (state)
            IDLE: begin
                if (any)
                    state_n = ISSUE;
            end
            ISSUE: begin
                accel_wrt_en    = (op == OP_WR);
                accel_rd_en     = (op == OP_RD);
                ch_grant[owner] = 1'b1;
                if (resp) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (resp) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op             <= OP_WR;
            owner          <= '0;
            ptr            <= '0;
            accel_addr     <= '0;
            accel_wrt_data <= '0;
            ch_wrt_done    <= '0;
            ch_rd_valid    <= '0;
            ch_err         <= '0;
            ch_rd_data     <= '0;
        end else begin
            ch_wrt_done <= '0;
            ch_rd_valid <= '0;
            ch_err      <= '0;
            if (state == IDLE && any) begin
                owner <= idx;
                // Write wins within a channel; its read waits for a later turn.
                if (ch_wrt_en[idx]) begin
                    op             <= OP_WR;
                    accel_addr     <= ch_wrt_addr[idx*ADDR_W +: ADDR_W];
                    accel_wrt_data <= ch_wrt_data[idx*DATA_W +: DATA_W];
                end else begin
                    op         <= OP_RD;
                    accel_addr <= ch_rd_addr[idx*ADDR_W +: ADDR_W];
                end
            end
            if (complete) begin
                ptr <= ptr_next;
                if (op == OP_WR) begin
                    ch_wrt_done[owner] <= 1'b1;
                end else begin
                    ch_rd_valid[owner] <= 1'b1;
                    ch_rd_data         <= accel_rd_data;
                end
            end
            if (tmo) begin
                ptr           <= ptr_next;
                ch_err[owner] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accel_port_arbiter.sv
// Testbench for accel_port_arbiter: directed and random transactions checked
// against a transaction-level round-robin model of the channels.
module tb_accel_port_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int RD_W   = 512;
    localparam int TMO    = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_wrt_en;
    logic [NUM_CH-1:0]        ch_rd_en;
    logic [NUM_CH*ADDR_W-1:0] ch_wrt_addr;
    logic [NUM_CH*ADDR_W-1:0] ch_rd_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wrt_data;
    logic [NUM_CH-1:0]        ch_grant;
    logic [NUM_CH-1:0]        ch_wrt_done;
    logic [NUM_CH-1:0]        ch_rd_valid;
    logic [NUM_CH-1:0]        ch_err;
    logic [RD_W-1:0]          ch_rd_data;
    logic [ADDR_W-1:0]        accel_addr;
    logic [DATA_W-1:0]        accel_wrt_data;
    logic                     accel_wrt_en;
    logic                     accel_rd_en;
    logic                     accel_wrt_done;
    logic                     accel_rd_valid;
    logic [RD_W-1:0]          accel_rd_data;

    accel_port_arbiter #(
        .NUM_CH      (NUM_CH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RD_W        (RD_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_wrt_en      (ch_wrt_en),
        .ch_rd_en       (ch_rd_en),
        .ch_wrt_addr    (ch_wrt_addr),
        .ch_rd_addr     (ch_rd_addr),
        .ch_wrt_data    (ch_wrt_data),
        .ch_grant       (ch_grant),
        .ch_wrt_done    (ch_wrt_done),
        .ch_rd_valid    (ch_rd_valid),
        .ch_err         (ch_err),
        .ch_rd_data     (ch_rd_data),
        .accel_addr     (accel_addr),
        .accel_wrt_data (accel_wrt_data),
        .accel_wrt_en   (accel_wrt_en),
        .accel_rd_en    (accel_rd_en),
        .accel_wrt_done (accel_wrt_done),
        .accel_rd_valid (accel_rd_valid),
        .accel_rd_data  (accel_rd_data)
    );

    always #5 clk = ~clk;

    // Model: pending requests per channel and the round-robin pointer.
    bit              wr_p [NUM_CH];
    bit              rd_p [NUM_CH];
    logic [15:0]     waddr[NUM_CH];
    logic [15:0]     raddr[NUM_CH];
    logic [31:0]     wdata[NUM_CH];
    int              mptr;
    logic [RD_W-1:0] last_rd;

    int nchk;
    int nfail;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RD_W-1:0] obs,
                       input logic [RD_W-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RD_W-1:0] rand_line();
        logic [RD_W-1:0] l;
        for (int i = 0; i < RD_W / 32; i++)
            l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wrt_en[i]                = wr_p[i];
            ch_rd_en[i]                 = rd_p[i];
            ch_wrt_addr[i*ADDR_W +: 16] = waddr[i];
            ch_rd_addr[i*ADDR_W +: 16]  = raddr[i];
            ch_wrt_data[i*DATA_W +: 32] = wdata[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_CH; i++) begin
            wr_p[i] = 1'b0;
            rd_p[i] = 1'b0;
        end
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < NUM_CH; k++)
            if (wr_p[(mptr + k) % NUM_CH] || rd_p[(mptr + k) % NUM_CH])
                return (mptr + k) % NUM_CH;
        return -1;
    endfunction

    // Wait for the expected grant and check the issued CPU command.
    task automatic await_grant(output int e, output bit isw, output bit ok);
        int n;
        e   = rr_pick();
        isw = (e >= 0) ? wr_p[e] : 1'b0;
        drive_reqs();
        n = 0;
        while (ch_grant == '0 && n < 6) begin
            step();
            n++;
            if (n == 1)
                chk("pulse_one_cycle", RD_W'({ch_wrt_done, ch_rd_valid, ch_err}), '0);
        end
        chk("grant_latency", RD_W'(n), RD_W'(1));
        chk("grant", RD_W'(ch_grant), RD_W'(4'b1 << e));
        ok = (ch_grant == (4'b1 << e));
        if (!ok)
            return;
        chk("wrt_en", RD_W'(accel_wrt_en), RD_W'(isw));
        chk("rd_en", RD_W'(accel_rd_en), RD_W'(!isw));
        chk("addr", RD_W'(accel_addr), RD_W'(isw ? waddr[e] : raddr[e]));
        if (isw)
            chk("wdata", RD_W'(accel_wrt_data), RD_W'(wdata[e]));
        if (isw)
            wr_p[e] = 1'b0;
        else
            rd_p[e] = 1'b0;
        drive_reqs();
    endtask

    // One full transaction: response after `delay` cycles, optionally with
    // the non-matching response asserted during the wait.
    task automatic serve(input int delay, input bit wrong,
                         output int e, output bit isw);
        bit              ok;
        logic [RD_W-1:0] line;
        await_grant(e, isw, ok);
        if (!ok)
            return;
        for (int i = 0; i < delay; i++) begin
            if (wrong) begin
                accel_wrt_done = !isw;
                accel_rd_valid = isw;
                accel_rd_data  = rand_line();
            end
            step();
            accel_wrt_done = 1'b0;
            accel_rd_valid = 1'b0;
            chk("wait_quiet", RD_W'({ch_grant, ch_wrt_done, ch_rd_valid, ch_err}), '0);
            chk("rd_hold", ch_rd_data, last_rd);
        end
        line = rand_line();
        accel_rd_data = line;
        if (isw)
            accel_wrt_done = 1'b1;
        else
            accel_rd_valid = 1'b1;
        step();
        accel_wrt_done = 1'b0;
        accel_rd_valid = 1'b0;
        mptr = (e + 1) % NUM_CH;
        if (!isw)
            last_rd = line;
        chk("wr_done", RD_W'(ch_wrt_done), isw ? RD_W'(4'b1 << e) : '0);
        chk("rd_valid", RD_W'(ch_rd_valid), isw ? '0 : RD_W'(4'b1 << e));
        chk("rd_data", ch_rd_data, last_rd);
        chk("no_err", RD_W'(ch_err), '0);
    endtask

    initial begin
        int e;
        bit isw;
        bit ok;
        int exp_own[5];
        bit exp_wr[5];
        nchk = 0;
        nfail = 0;
        mptr = 0;
        last_rd = '0;
        clear_model();
        for (int i = 0; i < NUM_CH; i++) begin
            waddr[i] = '0;
            raddr[i] = '0;
            wdata[i] = '0;
        end
        drive_reqs();
        accel_wrt_done = 1'b0;
        accel_rd_valid = 1'b0;
        accel_rd_data  = '0;
        rst = 1'b1;
        step();
        step();
        chk("rst_outs", RD_W'({ch_grant, ch_wrt_done, ch_rd_valid, ch_err}), '0);
        chk("rst_accel", RD_W'({accel_addr, accel_wrt_data, accel_wrt_en, accel_rd_en}), '0);
        chk("rst_rd_data", ch_rd_data, '0);
        rst = 1'b0;

        // Responses in IDLE must be ignored.
        accel_wrt_done = 1'b1;
        accel_rd_valid = 1'b1;
        accel_rd_data  = rand_line();
        step();
        accel_wrt_done = 1'b0;
        accel_rd_valid = 1'b0;
        step();
        chk("idle_resp", RD_W'({ch_grant, ch_wrt_done, ch_rd_valid}), '0);
        chk("idle_rd_data", ch_rd_data, '0);

        // All channels hold reads: order 0,1,2,3,0.
        for (int i = 0; i < NUM_CH; i++)
            raddr[i] = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                rd_p[c] = 1'b1;
            serve(i, 1'b0, e, isw);
            chk("rr_order", RD_W'(e), RD_W'(i % NUM_CH));
        end
        clear_model();

        // Channel 2 write, response two cycles after issue.
        waddr[2] = 16'h0010;
        wdata[2] = 32'hDEADBEEF;
        wr_p[2]  = 1'b1;
        serve(2, 1'b0, e, isw);
        chk("ch2_owner", RD_W'(e), RD_W'(2));

        // Move the pointer to channel 1, then ch1 write+read vs others' reads.
        wr_p[0] = 1'b1;
        wdata[0] = $urandom;
        serve(0, 1'b0, e, isw);
        exp_own = '{1, 2, 3, 0, 1};
        exp_wr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        wr_p[1] = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            rd_p[c] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            serve($urandom_range(0, 3), 1'b0, e, isw);
            chk("wr_rd_owner", RD_W'(e), RD_W'(exp_own[i]));
            chk("wr_rd_op", RD_W'(isw), RD_W'(exp_wr[i]));
        end

        // Mismatched response during a write wait is ignored.
        wr_p[3] = 1'b1;
        wdata[3] = $urandom;
        serve(3, 1'b1, e, isw);

`ifdef ACCEL_ARB_TIMEOUT_EN
        rd_p[1] = 1'b1;
        await_grant(e, isw, ok);
        for (int i = 0; i < TMO; i++) begin
            step();
            chk("tmo_quiet", RD_W'({ch_err, ch_rd_valid}), '0);
        end
        step();
        chk("tmo_err", RD_W'(ch_err), RD_W'(4'b1 << e));
        mptr = (e + 1) % NUM_CH;
        rd_p[1] = 1'b1;
        rd_p[2] = 1'b1;
        serve(0, 1'b0, e, isw);
        chk("tmo_next", RD_W'(e), RD_W'(2));
        clear_model();
`else
        // Without the timeout, a long wait stays quiet until the response.
        rd_p[1] = 1'b1;
        serve(25, 1'b0, e, isw);
`endif

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!wr_p[c] && $urandom_range(0, 2) == 0) begin
                    wr_p[c]  = 1'b1;
                    waddr[c] = 16'($urandom);
                    wdata[c] = $urandom;
                end
                if (!rd_p[c] && $urandom_range(0, 2) == 0) begin
                    rd_p[c]  = 1'b1;
                    raddr[c] = 16'($urandom);
                end
            end
            if (rr_pick() < 0)
                rd_p[$urandom_range(0, NUM_CH - 1)] = 1'b1;
            serve($urandom_range(0, 4), 1'($urandom_range(0, 1)), e, isw);
        end
        clear_model();

        // Complete a ch2 write so the pointer sits at 3, then abort a read.
        wr_p[2] = 1'b1;
        serve(0, 1'b0, e, isw);
        rd_p[1] = 1'b1;
        await_grant(e, isw, ok);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        accel_rd_valid = 1'b1;
        accel_rd_data  = rand_line();
        step();
        accel_rd_valid = 1'b0;
        mptr = 0;
        last_rd = '0;
        chk("abort_pulses", RD_W'({ch_grant, ch_wrt_done, ch_rd_valid, ch_err}), '0);
        chk("abort_accel", RD_W'({accel_addr, accel_wrt_data, accel_wrt_en, accel_rd_en}), '0);
        chk("abort_rd_data", ch_rd_data, '0);
        step();
        chk("abort_late", RD_W'({ch_wrt_done, ch_rd_valid}), '0);
        wr_p[0] = 1'b1;
        wr_p[3] = 1'b1;
        serve(1, 1'b0, e, isw);
        chk("ptr_reset", RD_W'(e), RD_W'(0));
        serve(0, 1'b0, e, isw);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
